// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: WIDTH-bit add/subtract built from one 4-bit carry
// look-ahead slice reused over WIDTH/4 cycles. Operands are latched on start,
// one nibble per cycle goes through the slice, and the slice carry-out is
// registered as the next carry-in. Sub is a + ~b + 1, with the +1 injected
// as the initial carry.
module cla_seq_adder_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ov
);

    localparam int unsigned NSL = WIDTH / 4;
    localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    // 4-bit CLA slice on the low nibble of the operand shift registers
    logic [3:0] g, p, nib;
    logic       c1, c2, c3, c4;

    assign g  = a_q[3:0] & b_q[3:0];
    assign p  = a_q[3:0] ^ b_q[3:0];
    assign c1 = g[0] | (p[0] & carry_q);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_q);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_q);
    assign nib = p ^ {c3, c2, c1, carry_q};

    // Register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    // Next-state and datapath sequencing: accept, run slices, complete
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Nibbles enter at the top so slice 0 ends up in the LSBs
                acc_d   = {nib, acc_q[WIDTH-1:4]};
                a_d     = {4'b0000, a_q[WIDTH-1:4]};
                b_d     = {4'b0000, b_q[WIDTH-1:4]};
                carry_d = c4;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NSL - 1)) begin
                    sum_d   = {nib, acc_q[WIDTH-1:4]};
                    co_d    = c4;
                    ov_d    = c3 ^ c4;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign co   = co_q;
    assign ov   = ov_q;

endmodule
